uart_tx_ctrl: RTL and testbench

//  Control and data-path stage of the UART transmitter, directly upstream of the registered TX output mux.

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/uart_tx_ctrl_if.sv | 23 ++
 rtl/uart_tx_serializer.sv | 36 +++
 rtl/uart_tx_ctrl.sv | 86 ++++++++
 tb/tb_uart_tx_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state encoding and TX mux select codes
package uart_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    // Select codes understood by the downstream registered TX output mux
    localparam logic [1:0] MUX_SEL_START = 2'b00;
    localparam logic [1:0] MUX_SEL_DATA  = 2'b01;
    localparam logic [1:0] MUX_SEL_PAR   = 2'b10;
    localparam logic [1:0] MUX_SEL_STOP  = 2'b11;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// rtl/uart_tx_ctrl_if.sv - byte input and mux-control bundle of the UART TX control stage
interface uart_tx_ctrl_if #(parameter int DATA_WIDTH = 8);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [1:0]            mux_sel;
    logic                  ser_data;
    logic                  par_bit;
    logic                  busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        input  mux_sel, ser_data, par_bit, busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        output mux_sel, ser_data, par_bit, busy
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - LSB-first shift register with frame bit counter
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ser_data,
    output logic                  ser_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= data_in;
            cnt   <= '0;
        end else if (shift_en) begin
            shreg <= shreg >> 1;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign ser_data = shreg[0];
    // Asserted during the last data bit so the FSM leaves DATA after exactly DATA_WIDTH cycles
    assign ser_done = (cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART TX frame sequencer driving the registered TX output mux
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_ctrl_if.slave bus
);

    state_t     state_q;
    state_t     state_d;
    logic       load;
    logic       shift_en;
    logic       ser_done;
    logic       par_en_q;
    logic       par_bit_q;
    logic [1:0] mux_sel_c;
    logic       busy_c;

    assign load     = (state_q == ST_IDLE) && bus.DATA_VALID;
    assign shift_en = (state_q == ST_DATA);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Parity mode and value are frozen at acceptance; mid-frame input changes are ignored
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (load) begin
            par_en_q  <= bus.PAR_EN;
            par_bit_q <= bus.PAR_TYP ? ~^bus.P_DATA : ^bus.P_DATA;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:   state_d = bus.DATA_VALID ? ST_START : ST_IDLE;
            ST_START:  state_d = ST_DATA;
            ST_DATA: begin
                if (!ser_done)     state_d = ST_DATA;
                else if (par_en_q) state_d = ST_PARITY;
                else               state_d = ST_STOP;
            end
            ST_PARITY: state_d = ST_STOP;
            ST_STOP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mux_sel_c = MUX_SEL_STOP;
        busy_c    = 1'b0;
        case (state_q)
            ST_START:  begin mux_sel_c = MUX_SEL_START; busy_c = 1'b1; end
            ST_DATA:   begin mux_sel_c = MUX_SEL_DATA;  busy_c = 1'b1; end
            ST_PARITY: begin mux_sel_c = MUX_SEL_PAR;   busy_c = 1'b1; end
            ST_STOP:   begin mux_sel_c = MUX_SEL_STOP;  busy_c = 1'b1; end
            default:   begin mux_sel_c = MUX_SEL_STOP;  busy_c = 1'b0; end
        endcase
    end

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_serializer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .shift_en (shift_en),
        .data_in  (bus.P_DATA),
        .ser_data (bus.ser_data),
        .ser_done (ser_done)
    );

    assign bus.mux_sel = mux_sel_c;
    assign bus.busy    = busy_c;
    assign bus.par_bit = par_bit_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl with a TX mux register model
module tb_uart_tx_ctrl;

    localparam int W = 8;

    logic CLK;
    logic RST;
    logic tx_out;
    int   total;
    int   bad;

    uart_tx_ctrl_if #(.DATA_WIDTH(W)) bus ();

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Downstream registered output mux: one cycle behind mux_sel
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) tx_out <= 1'b1;
        else begin
            case (bus.mux_sel)
                2'b00:   tx_out <= 1'b0;
                2'b01:   tx_out <= bus.ser_data;
                2'b10:   tx_out <= bus.par_bit;
                default: tx_out <= 1'b1;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_parity(input logic [W-1:0] d, input logic odd);
        int ones;
        ones = $countones(d);
        return odd ? logic'((ones + 1) % 2) : logic'(ones % 2);
    endfunction

    // Line level of frame cycle i: start, data LSB first, optional parity, stop
    function automatic logic ref_line(input int i, input logic [W-1:0] d, input logic pe, input logic par);
        if (i == 0) return 1'b0;
        if (i <= W) return logic'((d >> (i - 1)) & 1);
        if (pe && i == W + 1) return par;
        return 1'b1;
    endfunction

    function automatic logic [1:0] ref_sel(input int i, input logic pe);
        if (i == 0) return 2'b00;
        if (i <= W) return 2'b01;
        if (pe && i == W + 1) return 2'b10;
        return 2'b11;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_sel"}, 32'(bus.mux_sel), 32'd3);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Called at a negedge while idle; returns at the negedge of the first IDLE cycle after the frame
    task automatic run_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                             input logic hold_new, input logic [W-1:0] new_d);
        int   len;
        logic par;
        len = W + 2 + int'(pe);
        par = ref_parity(d, pt);
        bus.P_DATA = d; bus.PAR_EN = pe; bus.PAR_TYP = pt; bus.DATA_VALID = 1'b1;
        @(negedge CLK);
        if (hold_new) begin
            bus.P_DATA = new_d; bus.PAR_EN = ~pe; bus.PAR_TYP = ~pt;
        end else begin
            bus.DATA_VALID = 1'b0; bus.P_DATA = W'($urandom);
            bus.PAR_EN = 1'($urandom); bus.PAR_TYP = 1'($urandom);
        end
        for (int i = 0; i < len; i++) begin
            chk($sformatf("sel%0d", i), 32'(bus.mux_sel), 32'(ref_sel(i, pe)));
            chk($sformatf("busy%0d", i), 32'(bus.busy), 32'd1);
            chk($sformatf("par%0d", i), 32'(bus.par_bit), 32'(par));
            if (ref_sel(i, pe) == 2'b01)
                chk($sformatf("ser%0d", i), 32'(bus.ser_data), 32'(ref_line(i, d, pe, par)));
            chk($sformatf("tx%0d", i), 32'(tx_out), (i == 0) ? 32'd1 : 32'(ref_line(i - 1, d, pe, par)));
            @(negedge CLK);
        end
        check_idle("gap");
        chk("tx_stop", 32'(tx_out), 32'd1);
        chk("par_hold", 32'(bus.par_bit), 32'(par));
    endtask

    initial begin
        logic [W-1:0] rd;
        total = 0;
        bad = 0;
        RST = 1'b0;
        bus.P_DATA = '0; bus.DATA_VALID = 1'b0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            bus.P_DATA = W'($urandom); bus.DATA_VALID = 1'($urandom);
            bus.PAR_EN = 1'($urandom); bus.PAR_TYP = 1'($urandom);
            @(negedge CLK);
            check_idle("rst");
            chk("rst_par", 32'(bus.par_bit), 32'd0);
            chk("rst_ser", 32'(bus.ser_data), 32'd0);
        end
        bus.DATA_VALID = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        check_idle("post_rst");

        run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 8'h00);
        run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 8'h00);

        // New byte held valid mid-frame is taken only after one IDLE cycle
        run_frame(8'hA5, 1'b0, 1'b1, 1'b1, 8'h3C);
        run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 8'h00);

        // Reset during data bit 4
        bus.P_DATA = 8'h5A; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.DATA_VALID = 1'b1;
        @(negedge CLK);
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge CLK);
        chk("pre_abort_sel", 32'(bus.mux_sel), 32'd1);
        chk("pre_abort_ser", 32'(bus.ser_data), 32'(8'h5A >> 4 & 1));
        RST = 1'b0;
        #1;
        check_idle("abort");
        chk("abort_par", 32'(bus.par_bit), 32'd0);
        chk("abort_ser", 32'(bus.ser_data), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_idle("abort_rel");
        run_frame(8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);

        // Random frames separated by random idle gaps
        for (int f = 0; f < 8; f++) begin
            rd = W'($urandom);
            run_frame(rd, 1'($urandom), 1'($urandom), 1'b0, 8'h00);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                @(negedge CLK);
                check_idle("rnd_gap");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
